// File: rtl/button_events.sv
// rtl/button_events.sv - debounced levels and press/release/long/chord events for two push-buttons
//
// Purpose:
//   Conditions the two raw active-low board buttons into clean pressed levels
//   and single-cycle event pulses. Each button passes through a 2-flop
//   synchroniser, a debounce counter and a RELEASED/PRESSED/HELD state machine.
//   Index 0 of every internal array is button A and index 1 is button B.
//
// Parameters:
//   DEBOUNCE_CYCLES - consecutive differing cycles needed to accept a new level (>= 1)
//   LONG_CYCLES     - cycles after the press event before the long event fires (>= 1)
//
// Ports:
//   clk        in  system clock
//   rst        in  synchronous reset, active-high
//   button_a   in  raw button A pin, active-low, asynchronous
//   button_b   in  raw button B pin, active-low, asynchronous
//   a_level    out debounced A state, 1 = pressed
//   b_level    out debounced B state, 1 = pressed
//   a_press    out one-cycle pulse when A level rises
//   b_press    out one-cycle pulse when B level rises
//   a_release  out one-cycle pulse when A level falls
//   b_release  out one-cycle pulse when B level falls
//   a_long     out one-cycle pulse when A has been held LONG_CYCLES, once per press
//   b_long     out one-cycle pulse when B has been held LONG_CYCLES, once per press
//   both_press out one-cycle pulse when A and B become pressed together

module button_events #(
  parameter int unsigned DEBOUNCE_CYCLES = 120_000,
  parameter int unsigned LONG_CYCLES     = 12_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button_a,
  input  logic button_b,
  output logic a_level,
  output logic b_level,
  output logic a_press,
  output logic b_press,
  output logic a_release,
  output logic b_release,
  output logic a_long,
  output logic b_long,
  output logic both_press
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

  // Counter values one step short of the limit: the edge that would reach
  // the limit is the edge that acts.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  localparam logic [1:0] ST_RELEASED = 2'd0;
  localparam logic [1:0] ST_PRESSED  = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;

  logic [1:0]        meta_q;
  logic [1:0]        sync_q;
  logic [1:0]        level_q,   level_d;
  logic [1:0]        press_q,   press_d;
  logic [1:0]        release_q, release_d;
  logic [1:0]        long_q,    long_d;
  logic              both_q,    both_d;
  logic [DB_W-1:0]   db_cnt_q [2];
  logic [DB_W-1:0]   db_cnt_d [2];
  logic [HOLD_W-1:0] hold_q   [2];
  logic [HOLD_W-1:0] hold_d   [2];
  logic [1:0]        state_q  [2];
  logic [1:0]        state_d  [2];

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      hold_d[i]   = hold_q[i];
      state_d[i]  = state_q[i];

      // Any cycle where the synchronised input agrees with the level leaves
      // the counter cleared, so a bounce restarts the count from zero.
      if (sync_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          level_d[i] = sync_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end

      case (state_q[i])
        ST_RELEASED: begin
          if (level_d[i]) begin
            press_d[i] = 1'b1;
            hold_d[i]  = '0;
            state_d[i] = ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          // A release accepted on the same edge as the long threshold wins.
          if (!level_d[i]) begin
            release_d[i] = 1'b1;
            state_d[i]   = ST_RELEASED;
          end else begin
            hold_d[i] = hold_q[i] + 1'b1;
            if (hold_q[i] == HOLD_LAST) begin
              long_d[i]  = 1'b1;
              state_d[i] = ST_HELD;
            end
          end
        end
        ST_HELD: begin
          // Hold counter stays saturated at LONG_CYCLES here.
          if (!level_d[i]) begin
            release_d[i] = 1'b1;
            state_d[i]   = ST_RELEASED;
          end
        end
        default: begin
          state_d[i] = ST_RELEASED;
        end
      endcase
    end

    both_d = (&level_d) & ~(&level_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q    <= '0;
      sync_q    <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      both_q    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
        hold_q[i]   <= '0;
        state_q[i]  <= ST_RELEASED;
      end
    end else begin
      // Pins are active-low; the synchroniser carries 1 = pressed.
      meta_q    <= ~{button_b, button_a};
      sync_q    <= meta_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      both_q    <= both_d;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
        hold_q[i]   <= hold_d[i];
        state_q[i]  <= state_d[i];
      end
    end
  end

  assign a_level    = level_q[0];
  assign b_level    = level_q[1];
  assign a_press    = press_q[0];
  assign b_press    = press_q[1];
  assign a_release  = release_q[0];
  assign b_release  = release_q[1];
  assign a_long     = long_q[0];
  assign b_long     = long_q[1];
  assign both_press = both_q;

endmodule

// File: tb/tb_button_events.sv
// tb/tb_button_events.sv - scoreboard bench for button_events with directed and random pin activity

module tb_button_events;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic button_a = 1'b1;
  logic button_b = 1'b1;
  logic a_level, b_level, a_press, b_press, a_release, b_release;
  logic a_long, b_long, both_press;

  button_events #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .button_a(button_a),
    .button_b(button_b),
    .a_level(a_level),
    .b_level(b_level),
    .a_press(a_press),
    .b_press(b_press),
    .a_release(a_release),
    .b_release(b_release),
    .a_long(a_long),
    .b_long(b_long),
    .both_press(both_press)
  );

  always #5 clk = ~clk;

  // Output vector order: {a_level, b_level, a_press, b_press, a_release,
  //                       b_release, a_long, b_long, both_press}
  typedef struct {
    int         cyc;
    logic [8:0] vec;
  } rec_t;

  rec_t exp_q[$];
  int   cyc     = 0;
  int   nvec    = 0;
  int   nfail   = 0;
  int   n_press = 0;
  int   n_long  = 0;
  int   n_both  = 0;

  // Reference model: a two-sample delay for the synchroniser, a window of the
  // last D synchronised samples since reset, and timestamps for long-press.
  bit   dly   [2][2];
  bit   win   [2][D];
  int   nsamp [2];
  bit   lvl   [2];
  bit   pend  [2];
  int   ptime [2];
  logic [8:0] last_exp = '0;

  always @(posedge clk) begin
    bit   pin   [2];
    bit   press [2];
    bit   rel   [2];
    bit   lng   [2];
    bit   both;
    bit   all_diff;
    bit   s;
    logic [8:0] v;
    cyc++;
    pin[0] = ~button_a;
    pin[1] = ~button_b;
    both = 1'b0;
    for (int i = 0; i < 2; i++) begin
      press[i] = 1'b0;
      rel[i]   = 1'b0;
      lng[i]   = 1'b0;
    end
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        dly[i][0] = 1'b0;
        dly[i][1] = 1'b0;
        nsamp[i]  = 0;
        lvl[i]    = 1'b0;
        pend[i]   = 1'b0;
      end
    end else begin
      bit old_both;
      old_both = lvl[0] & lvl[1];
      for (int i = 0; i < 2; i++) begin
        s = dly[i][1];
        dly[i][1] = dly[i][0];
        dly[i][0] = pin[i];
        win[i][nsamp[i] % D] = s;
        nsamp[i]++;
        all_diff = (nsamp[i] >= D);
        for (int k = 0; k < D; k++)
          if (win[i][k] == lvl[i]) all_diff = 1'b0;
        if (all_diff) begin
          lvl[i] = ~lvl[i];
          if (lvl[i]) begin
            press[i] = 1'b1;
            pend[i]  = 1'b1;
            ptime[i] = cyc;
          end else begin
            rel[i]  = 1'b1;
            pend[i] = 1'b0;
          end
        end else if (pend[i] && lvl[i] && (cyc - ptime[i] == L)) begin
          lng[i]  = 1'b1;
          pend[i] = 1'b0;
        end
      end
      both = (lvl[0] & lvl[1]) & ~old_both;
    end
    if (press[0] || press[1]) n_press++;
    if (lng[0] || lng[1]) n_long++;
    if (both) n_both++;
    v = {lvl[0], lvl[1], press[0], press[1], rel[0], rel[1], lng[0], lng[1], both};
    if (v != last_exp) begin
      rec_t r;
      r.cyc = cyc;
      r.vec = v;
      exp_q.push_back(r);
    end
    last_exp = v;
  end

  // Monitor: whenever the DUT outputs change, or the scoreboard holds an
  // entry for this cycle, pop and compare.
  logic [8:0] prev_dut = '0;
  logic [8:0] exp_last = '0;

  always @(negedge clk) begin
    logic [8:0] dv;
    logic [8:0] ev;
    bit         has_exp;
    if (cyc >= 1) begin
      dv = {a_level, b_level, a_press, b_press, a_release, b_release, a_long, b_long, both_press};
      has_exp = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      if (dv !== prev_dut || has_exp) begin
        ev = exp_last;
        if (has_exp) begin
          rec_t r;
          r = exp_q.pop_front();
          ev = r.vec;
        end
        nvec++;
        if (dv !== ev) begin
          nfail++;
          $display("FAIL outputs cycle %0d: got %b expected %b", cyc, dv, ev);
        end
        exp_last = ev;
      end
      prev_dut = dv;
    end
  end

  task automatic drive(input logic a, input logic b, input logic r, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      button_a = a;
      button_b = b;
      rst      = r;
    end
  endtask

  initial begin
    // 1: reset then idle
    drive(1, 1, 1, 3);
    drive(1, 1, 0, 50);
    // 2: clean A press and release
    drive(0, 1, 0, 30);
    drive(1, 1, 0, 30);
    // 3: B bounce then stable low
    for (int t = 0; t < 6; t++) drive(1, t[0], 0, 2);
    drive(1, 0, 0, 20);
    drive(1, 1, 0, 20);
    // 4: A long press
    drive(0, 1, 0, 40);
    drive(1, 1, 0, 30);
    // 5: chord, release B, chord again
    drive(0, 1, 0, 3);
    drive(0, 0, 0, 30);
    drive(0, 1, 0, 10);
    drive(0, 0, 0, 30);
    drive(1, 1, 0, 30);
    // 6: reset mid-press with A held low
    drive(0, 1, 0, 20);
    drive(0, 1, 1, 2);
    drive(0, 1, 0, 40);
    drive(1, 1, 0, 30);
    // same-cycle chord
    drive(0, 0, 0, 35);
    drive(1, 1, 0, 20);
    // random activity: mixes of bounces, holds and occasional resets
    for (int seg = 0; seg < 400; seg++) begin
      int len;
      if ($urandom_range(0, 39) == 0) begin
        drive($urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom_range(1, 3));
      end else begin
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 40);
        drive($urandom_range(0, 1), $urandom_range(0, 1), 0, len);
      end
    end
    drive(1, 1, 0, 60);
    @(negedge clk);
    nvec++;
    if (exp_q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    nvec++;
    if (n_press == 0 || n_long == 0 || n_both == 0) begin
      nfail++;
      $display("FAIL activity: got press=%0d long=%0d both=%0d expected all nonzero",
               n_press, n_long, n_both);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
